// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind valid/ready request and response channels.
// It inserts WAIT_CYCLES wait states between accepting a request and the memory access.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ready_nxt;
  logic              valid_nxt;
  logic [CNT_W-1:0]  cnt;

  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept_c;
  logic              do_access_c;
  logic              acc_we_c;
  logic [31:0]       acc_addr_c;
  logic [31:0]       acc_wdata_c;
  logic [3:0]        acc_be_c;
  logic              acc_err_c;
  logic [IDX_W-1:0]  acc_idx_c;
  logic [31:0]       rd_word_c;
  logic [31:0]       wr_word_c;

  assign accept_c = req_valid_i & req_ready_o;

  // With zero wait states the access happens on the accept edge, so it must use the live request.
  assign do_access_c = ((state == ST_IDLE) && accept_c && (WAIT_INIT == '0)) ||
                       ((state == ST_WAIT) && (cnt == CNT_W'(1)));

  always_comb begin
    acc_we_c    = lat_we;
    acc_addr_c  = lat_addr;
    acc_wdata_c = lat_wdata;
    acc_be_c    = lat_be;
    if (state == ST_IDLE) begin
      acc_we_c    = req_we_i;
      acc_addr_c  = req_addr_i;
      acc_wdata_c = req_wdata_i;
      acc_be_c    = req_be_i;
    end
  end

  assign acc_err_c = (|acc_addr_c[1:0]) | (|acc_addr_c[31:IDX_W+2]);
  assign acc_idx_c = acc_addr_c[IDX_W+1:2];
  assign rd_word_c = mem[acc_idx_c];

  // Merge the enabled store lanes into the current word.
  always_comb begin
    wr_word_c = rd_word_c;
    for (int k = 0; k < 4; k++) begin
      if (acc_be_c[k]) begin
        wr_word_c[8*k +: 8] = acc_wdata_c[8*k +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_nxt = (WAIT_INIT == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_o && rsp_ready_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    ready_nxt = 1'b0;
    valid_nxt = 1'b0;
    unique case (state_nxt)
      ST_IDLE: ready_nxt = 1'b1;
      ST_RESP: valid_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      cnt         <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
    end else begin
      req_ready_o <= ready_nxt;
      rsp_valid_o <= valid_nxt;
      if (accept_c) begin
        lat_we    <= req_we_i;
        lat_addr  <= req_addr_i;
        lat_wdata <= req_wdata_i;
        lat_be    <= req_be_i;
        cnt       <= WAIT_INIT;
      end else if ((state == ST_WAIT) && (cnt > CNT_W'(1))) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (do_access_c) begin
        rsp_rdata_o <= (acc_err_c || acc_we_c) ? 32'd0 : rd_word_c;
        rsp_err_o   <= acc_err_c;
      end else if ((state == ST_RESP) && rsp_valid_o && rsp_ready_i) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b0;
      end
    end
  end

  // Storage; only in-range aligned stores commit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem[i] <= '0;
      end
    end else if (do_access_c && acc_we_c && !acc_err_c) begin
      mem[acc_idx_c] <= wr_word_c;
    end
  end

endmodule
